vscale_dmem_ctrl: RTL and testbench

- Data-memory controller directly downstream of the core's dmem port.
- Accepts the core's split-phase access: command in DX, store data one cycle later in WB.
- Checks alignment and range, forms byte-lane masks, and runs a valid/ready request plus response-valid handshake to backing memory.
- Returns sign/zero-extended load data, and holds the core with dmem_wait until the access completes.

---
 rtl/vscale_dmem_ctrl_pkg.sv | 33 +++
 rtl/vscale_dmem_ctrl_if.sv | 39 +++
 rtl/vscale_dmem_align.sv | 47 ++++
 rtl/vscale_dmem_ctrl.sv | 144 ++++++++++++++
 tb/tb_vscale_dmem_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vscale_dmem_ctrl_pkg.sv
// Shared constants for the vscale data-memory controller: funct3 access-size codes and FSM state encodings.
// Latency: none (definitions only).
// Backpressure: not applicable.
package vscale_dmem_ctrl_pkg;

  localparam int MEM_TYPE_WIDTH = 3;

  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_B  = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_H  = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_W  = 3'd2;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_BU = 3'd4;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_HU = 3'd5;

  localparam int DMEM_STATE_WIDTH = 3;

  typedef enum logic [DMEM_STATE_WIDTH-1:0] {
    DMEM_STATE_IDLE  = 3'd0,
    DMEM_STATE_REQ   = 3'd1,
    DMEM_STATE_RESP  = 3'd2,
    DMEM_STATE_FAULT = 3'd3,
    DMEM_STATE_DONE  = 3'd4
  } dmem_state_e;

  function automatic logic mem_type_legal(input logic [MEM_TYPE_WIDTH-1:0] t);
    logic ok;
    case (t)
      MEM_TYPE_B, MEM_TYPE_H, MEM_TYPE_W, MEM_TYPE_BU, MEM_TYPE_HU: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/vscale_dmem_ctrl_if.sv
// Core dmem port plus backing-memory request/response bundle.
// Latency: none (wiring only).
// Backpressure: mem_req_ready throttles requests; dmem_wait throttles the core.
interface vscale_dmem_ctrl_if;
  import vscale_dmem_ctrl_pkg::*;

  logic                      dmem_en;
  logic                      dmem_wen;
  logic [MEM_TYPE_WIDTH-1:0] dmem_size;
  logic [31:0]               dmem_addr;
  logic [31:0]               dmem_wdata_delayed;
  logic [31:0]               dmem_rdata;
  logic                      dmem_wait;
  logic                      dmem_badmem_e;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [31:0]               mem_req_addr;
  logic                      mem_req_wen;
  logic [3:0]                mem_req_wmask;
  logic [31:0]               mem_req_wdata;
  logic                      mem_resp_valid;
  logic [31:0]               mem_resp_rdata;

  modport slave (
    input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output dmem_rdata, dmem_wait, dmem_badmem_e,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata
  );

  modport master (
    output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  dmem_rdata, dmem_wait, dmem_badmem_e,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata
  );

endinterface

// File: rtl/vscale_dmem_align.sv
// Byte-lane steering: store mask/replication, load lane select with sign/zero extension, misalignment flag.
// Latency: combinational.
// Backpressure: none.
module vscale_dmem_align
  import vscale_dmem_ctrl_pkg::*;
(
  input  logic [MEM_TYPE_WIDTH-1:0] size_i,
  input  logic [1:0]                addr_lo_i,
  input  logic [31:0]               wdata_i,
  input  logic [31:0]               rdata_i,
  output logic [3:0]                wmask_o,
  output logic [31:0]               wdata_o,
  output logic [31:0]               rdata_o,
  output logic                      misaligned_o
);

  logic [31:0] rdata_shift;

  assign rdata_shift = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    wmask_o      = 4'b0000;
    wdata_o      = wdata_i;
    rdata_o      = 32'h0;
    misaligned_o = 1'b0;
    case (size_i)
      MEM_TYPE_B, MEM_TYPE_BU: begin
        wmask_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{rdata_shift[7] & (size_i == MEM_TYPE_B)}}, rdata_shift[7:0]};
      end
      MEM_TYPE_H, MEM_TYPE_HU: begin
        wmask_o      = 4'b0011 << addr_lo_i;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {{16{rdata_shift[15] & (size_i == MEM_TYPE_H)}}, rdata_shift[15:0]};
        misaligned_o = addr_lo_i[0];
      end
      MEM_TYPE_W: begin
        wmask_o      = 4'b1111;
        rdata_o      = rdata_i;
        misaligned_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vscale_dmem_ctrl.sv
// Data-memory controller: core split-phase dmem port to valid/ready backing memory with fault checks.
// Latency: one core stall minimum; VSCALE_DMEM_RDATA_REG_EN registers load data and adds one more.
// Backpressure: dmem_wait holds core WB until completion; request fields hold while mem_req_ready is low.
module vscale_dmem_ctrl
  import vscale_dmem_ctrl_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0001_0000
) (
  input logic               clk,
  input logic               reset,
  vscale_dmem_ctrl_if.slave bus
);

  dmem_state_e               state_q, state_d;
  logic [31:0]               addr_q, addr_d;
  logic [MEM_TYPE_WIDTH-1:0] size_q, size_d;
  logic                      wen_q, wen_d;

  logic        dx_misaligned;
  logic [32:0] dx_offset;
  logic        dx_out_of_range;
  logic        dx_fault;

  logic [3:0]  wb_wmask;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata;

  logic [3:0]  unused_dx_wmask;
  logic [31:0] unused_dx_wdata;
  logic [31:0] unused_dx_rdata;
  logic        unused_wb_misaligned;

`ifdef VSCALE_DMEM_RDATA_REG_EN
  logic [31:0] rdata_q, rdata_d;
`endif

  // DX-side copy only feeds the alignment check on the incoming command.
  vscale_dmem_align u_align_dx (
    .size_i       (bus.dmem_size),
    .addr_lo_i    (bus.dmem_addr[1:0]),
    .wdata_i      (32'h0),
    .rdata_i      (32'h0),
    .wmask_o      (unused_dx_wmask),
    .wdata_o      (unused_dx_wdata),
    .rdata_o      (unused_dx_rdata),
    .misaligned_o (dx_misaligned)
  );

  vscale_dmem_align u_align_wb (
    .size_i       (size_q),
    .addr_lo_i    (addr_q[1:0]),
    .wdata_i      (bus.dmem_wdata_delayed),
    .rdata_i      (bus.mem_resp_rdata),
    .wmask_o      (wb_wmask),
    .wdata_o      (wb_wdata),
    .rdata_o      (wb_rdata),
    .misaligned_o (unused_wb_misaligned)
  );

  // 33-bit offset: bit 32 flags addr below MEM_BASE, and the window top cannot wrap.
  assign dx_offset       = {1'b0, bus.dmem_addr} - {1'b0, MEM_BASE};
  assign dx_out_of_range = dx_offset[32] | (dx_offset[31:0] >= MEM_SIZE);
  assign dx_fault        = dx_misaligned | dx_out_of_range | !mem_type_legal(bus.dmem_size);

  assign bus.mem_req_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_req_wen   = wen_q;
  assign bus.mem_req_wmask = wb_wmask;
  assign bus.mem_req_wdata = wb_wdata;

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    size_d            = size_q;
    wen_d             = wen_q;
    bus.dmem_wait     = 1'b0;
    bus.dmem_badmem_e = 1'b0;
    bus.dmem_rdata    = 32'h0;
    bus.mem_req_valid = 1'b0;
`ifdef VSCALE_DMEM_RDATA_REG_EN
    rdata_d           = rdata_q;
`endif

    case (state_q)
      DMEM_STATE_IDLE: ;
      DMEM_STATE_FAULT: bus.dmem_badmem_e = 1'b1;
      DMEM_STATE_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.dmem_wait     = 1'b1;
        if (bus.mem_req_ready) state_d = DMEM_STATE_RESP;
      end
      DMEM_STATE_RESP: begin
`ifdef VSCALE_DMEM_RDATA_REG_EN
        bus.dmem_wait = 1'b1;
        if (bus.mem_resp_valid) begin
          state_d = DMEM_STATE_DONE;
          rdata_d = wen_q ? 32'h0 : wb_rdata;
        end
`else
        bus.dmem_wait = !bus.mem_resp_valid;
        if (bus.mem_resp_valid && !wen_q) bus.dmem_rdata = wb_rdata;
`endif
      end
`ifdef VSCALE_DMEM_RDATA_REG_EN
      DMEM_STATE_DONE: bus.dmem_rdata = rdata_q;
`endif
      default: state_d = DMEM_STATE_IDLE;
    endcase

    // Any cycle the core is not held is an acceptance slot, including completion cycles.
    if (!bus.dmem_wait) begin
      if (bus.dmem_en) begin
        state_d = dx_fault ? DMEM_STATE_FAULT : DMEM_STATE_REQ;
        addr_d  = bus.dmem_addr;
        size_d  = bus.dmem_size;
        wen_d   = bus.dmem_wen;
      end else begin
        state_d = DMEM_STATE_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DMEM_STATE_IDLE;
      addr_q  <= 32'h0;
      size_q  <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
    end
  end

`ifdef VSCALE_DMEM_RDATA_REG_EN
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= 32'h0;
    else       rdata_q <= rdata_d;
  end
`endif

endmodule

// File: tb/tb_vscale_dmem_ctrl.sv
// Scoreboard bench for vscale_dmem_ctrl: core-side driver, backing-memory model, completion monitor.
// Latency: not applicable.
// Backpressure: memory model stalls ready and delays responses per transaction.
module tb_vscale_dmem_ctrl;
  import vscale_dmem_ctrl_pkg::*;

`ifdef VSCALE_DMEM_RDATA_REG_EN
  localparam int XS = 1;
`else
  localparam int XS = 0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        badmem;
    int          stalls;
  } sb_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    int          rdy_dly;
    int          resp_dly;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  sb_t  sb_q[$];
  req_t req_q[$];
  logic [31:0] mem_q [logic [31:0]];
  logic in_wb = 1'b0;
  int   wb_stalls = 0;
  logic late_seen;

  vscale_dmem_ctrl_if bus();

  vscale_dmem_ctrl #(
    .MEM_BASE (32'h0000_0000),
    .MEM_SIZE (32'h0001_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one access at posedge+1; returns at posedge+1 of its WB cycle.
  task automatic access(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic fault,
                        input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                        input int rdy_dly, input int resp_dly);
    logic acc;
    sb_q.push_back('{exp_rdata, fault, fault ? 0 : rdy_dly + resp_dly + XS});
    if (!fault)
      req_q.push_back('{{addr[31:2], 2'b00}, wen, exp_mask, exp_wdata, rdy_dly, resp_dly});
    bus.dmem_en   = 1'b1;
    bus.dmem_wen  = wen;
    bus.dmem_size = size;
    bus.dmem_addr = addr;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = !bus.dmem_wait;
      @(posedge clk);
      #1;
    end
    chk("accept", 32'(acc), 32'd1);
    bus.dmem_en = 1'b0;
    if (wen) bus.dmem_wdata_delayed = wdata;
  endtask

  // Backing memory: checks request fields every REQ cycle, answers per the queued delays.
  initial begin
    int          rdy_cnt;
    int          resp_cnt;
    logic [31:0] pend;
    logic [31:0] w;
    req_t        r;
    rdy_cnt = 0;
    resp_cnt = 0;
    pend = 32'h0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = 32'h0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_rdata = pend;
        end
      end else if (req_q.size() == 0) begin
        chk("no_req_valid", 32'(bus.mem_req_valid), 32'd0);
      end else if (bus.mem_req_valid) begin
        r = req_q[0];
        chk("req_addr", bus.mem_req_addr, r.addr);
        chk("req_wen", 32'(bus.mem_req_wen), 32'(r.wen));
        chk("req_wmask", 32'(bus.mem_req_wmask), 32'(r.wmask));
        if (r.wen) chk("req_wdata", bus.mem_req_wdata, r.wdata);
        if (rdy_cnt < r.rdy_dly) begin
          rdy_cnt++;
        end else begin
          bus.mem_req_ready = 1'b1;
          rdy_cnt = 0;
          resp_cnt = r.resp_dly;
          w = mem_q.exists(r.addr) ? mem_q[r.addr] : 32'h0;
          if (r.wen) begin
            for (int b = 0; b < 4; b++)
              if (r.wmask[b]) w[8*b +: 8] = r.wdata[8*b +: 8];
            mem_q[r.addr] = w;
            pend = 32'hFFFF_FFFF;
          end else begin
            pend = w;
          end
          void'(req_q.pop_front());
        end
      end
    end
  end

  // Completion monitor: an access accepted at a posedge completes on the first WB cycle with dmem_wait low.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_wb = 1'b0;
        wb_stalls = 0;
      end else begin
        if (in_wb) begin
          if (bus.dmem_wait) begin
            wb_stalls++;
            chk("stall_badmem", 32'(bus.dmem_badmem_e), 32'd0);
          end else begin
            if (sb_q.size() == 0) begin
              chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
            end else begin
              e = sb_q.pop_front();
              chk("rdata", bus.dmem_rdata, e.rdata);
              chk("badmem", 32'(bus.dmem_badmem_e), 32'(e.badmem));
              chk("stalls", 32'(wb_stalls), 32'(e.stalls));
            end
            in_wb = 1'b0;
            wb_stalls = 0;
          end
        end
        if (bus.dmem_en && !bus.dmem_wait) begin
          in_wb = 1'b1;
          wb_stalls = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.dmem_en = 1'b0;
    bus.dmem_wen = 1'b0;
    bus.dmem_size = MEM_TYPE_B;
    bus.dmem_addr = 32'h0;
    bus.dmem_wdata_delayed = 32'h0;
    mem_q[32'h100] = 32'h80FF_7F01;
    mem_q[32'h200] = 32'h0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_wait", 32'(bus.dmem_wait), 32'd0);
    chk("rst_badmem", 32'(bus.dmem_badmem_e), 32'd0);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_rdata", bus.dmem_rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // wen, size, addr, wdata, exp rdata, fault, mask, wdata on bus, ready delay, resp delay
    access(0, MEM_TYPE_B,  32'h103, 32'h0, 32'hFFFF_FF80, 0, 4'b1000, 32'h0, 0, 1);
    access(0, MEM_TYPE_W,  32'h100, 32'h0, 32'h80FF_7F01, 0, 4'b1111, 32'h0, 0, 1);
    access(0, MEM_TYPE_H,  32'h100, 32'h0, 32'h0000_7F01, 0, 4'b0011, 32'h0, 0, 1);
    access(0, MEM_TYPE_H,  32'h102, 32'h0, 32'hFFFF_80FF, 0, 4'b1100, 32'h0, 0, 1);
    access(0, MEM_TYPE_BU, 32'h103, 32'h0, 32'h0000_0080, 0, 4'b1000, 32'h0, 0, 1);
    access(0, MEM_TYPE_B,  32'h101, 32'h0, 32'h0000_007F, 0, 4'b0010, 32'h0, 0, 1);
    access(1, MEM_TYPE_W,  32'h100, 32'hBEEF_1234, 32'h0, 0, 4'b1111, 32'hBEEF_1234, 0, 1);
    access(0, MEM_TYPE_HU, 32'h102, 32'h0, 32'h0000_BEEF, 0, 4'b1100, 32'h0, 0, 1);
    access(1, MEM_TYPE_W,  32'h200, 32'hDEAD_BEEF, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF, 0, 1);
    access(1, MEM_TYPE_B,  32'h201, 32'h0000_00AA, 32'h0, 0, 4'b0010, 32'hAAAA_AAAA, 0, 1);
    access(1, MEM_TYPE_H,  32'h202, 32'h0000_5678, 32'h0, 0, 4'b1100, 32'h5678_5678, 0, 1);
    access(0, MEM_TYPE_W,  32'h200, 32'h0, 32'h5678_AAEF, 0, 4'b1111, 32'h0, 0, 1);
    access(0, MEM_TYPE_B,  32'h202, 32'h0, 32'h0000_0078, 0, 4'b0100, 32'h0, 0, 1);

    access(0, MEM_TYPE_W,  32'h102, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 0, 1);
    access(1, MEM_TYPE_W,  32'h0001_0000, 32'h1111_1111, 32'h0, 1, 4'b0000, 32'h0, 0, 1);
    access(0, MEM_TYPE_H,  32'h101, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 0, 1);
    access(0, 3'd3,        32'h000, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 0, 1);
    access(1, MEM_TYPE_B,  32'hFFFF_FFFF, 32'h22, 32'h0, 1, 4'b0000, 32'h0, 0, 1);

    access(0, MEM_TYPE_W,  32'h100, 32'h0, 32'hBEEF_1234, 0, 4'b1111, 32'h0, 3, 2);
    access(0, MEM_TYPE_W,  32'h200, 32'h0, 32'h5678_AAEF, 0, 4'b1111, 32'h0, 0, 1);

    // Reset while the access sits in RESP; its response arrives afterwards and must be dropped.
    access(0, MEM_TYPE_W,  32'h100, 32'h0, 32'hBEEF_1234, 0, 4'b1111, 32'h0, 0, 4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("post_rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("post_rst_wait", 32'(bus.dmem_wait), 32'd0);
    late_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.mem_resp_valid) begin
        late_seen = 1'b1;
        chk("late_wait", 32'(bus.dmem_wait), 32'd0);
        chk("late_rdata", bus.dmem_rdata, 32'h0);
      end
    end
    chk("late_resp_seen", 32'(late_seen), 32'd1);
    @(posedge clk);
    #1;
    access(0, MEM_TYPE_W,  32'h100, 32'h0, 32'hBEEF_1234, 0, 4'b1111, 32'h0, 0, 1);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 30 && (in_wb || sb_q.size() != 0); i++) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("req_drained", 32'(req_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
